// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 keyboard receiver plus make/break scan-code tracker.
// Latency: key_code/rx_byte/strobes update one cycle after the STOP edge is detected; frame_err is coincident with it.
// No backpressure: bytes arrive at PS/2 pace, key_code is a held level. Optional macro: PS2_PARITY_CHECK_EN (enforce odd parity).
module ps2_kb_rx #(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  // Frame FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [17:0] TO_LAST = 18'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;
  logic bit_in;

  // Two-flop synchronizers plus an edge register; reset high because the bus idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Data and clock share synchronizer depth, so bit_in is the pad value at the falling edge
  assign fall   = clk_prev_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  // ---------------------------------------------------------------------
  // Frame FSM and timeout
  // ---------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [17:0] to_cnt_q, to_cnt_d;
  logic        parity_ok;
  logic        timeout_hit;
  logic        good_frame;
  logic        err;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must contain an odd number of ones
  assign parity_ok = ^{shift_q, par_q};
`else
  // Parity bit is clocked in but deliberately not checked
  logic unused_par;
  assign unused_par = par_q;
  assign parity_ok  = 1'b1;
`endif

  // A real edge always takes priority over the timeout terminal count
  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST) && !fall;

  // Next-state logic for frame deserialization and the stall timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    good_frame = 1'b0;
    err        = 1'b0;

    if (fall || (state_q == ST_IDLE)) begin
      to_cnt_d = 18'd0;
    end else begin
      to_cnt_d = to_cnt_q + 18'd1;
    end

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            // Start bit must be low; a high one is a framing error
            err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
        default: begin
          if (bit_in && parity_ok) begin
            good_frame = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      // Returning to IDLE clears the counter, so this fires only once per stall
      state_d = ST_IDLE;
      err     = 1'b1;
    end
  end

  // Frame FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      to_cnt_q  <= 18'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code tracker
  // ---------------------------------------------------------------------
  logic [7:0] key_q, key_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  // ext is tracked so prefixes are consumed, but extended keys map to their plain code
  logic unused_ext;
  assign unused_ext = ext_q;

  // Prefix flags and held-key update, evaluated only on good frames
  always_comb begin
    key_d       = key_q;
    key_valid_d = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;

    if (good_frame) begin
      rx_byte_d   = shift_q;
      rx_strobe_d = 1'b1;
      if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          // Make: last-pressed wins; typematic repeats do not pulse
          if (shift_q != key_q) begin
            key_d       = shift_q;
            key_valid_d = 1'b1;
          end
        end else begin
          // Break: only releases the key currently held
          if ((shift_q == key_q) && (key_q != 8'h00)) begin
            key_d       = 8'h00;
            key_valid_d = 1'b1;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Tracker and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign key_code  = key_q;
  assign key_valid = key_valid_q;
  assign rx_byte   = rx_byte_q;
  assign rx_strobe = rx_strobe_q;
  // All terms come from registers, so this pulse is clean for one cycle
  assign frame_err = err;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: table of single-frame vectors plus hand sequences for
// start/stop errors, stall timeout and reset mid-frame.
module tb_ps2_kb_rx;

  localparam int unsigned TO_CYC = 300;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_valid;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  ps2_kb_rx #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int st_cnt = 0;
  int err_cnt = 0;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (rx_strobe === 1'b1) st_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [7:0] dat;
    bit         bad_par;
    logic [7:0] exp_key;
    logic [7:0] exp_rx;
    int         exp_kv;
    int         exp_st;
    int         exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    #1;
    kv_cnt  = 0;
    st_cnt  = 0;
    err_cnt = 0;
  endtask

  // Drive n PS/2 bits, LSB first; device changes data while the clock is high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    logic [10:0] bits;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    send_bits(bits, 11);
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic chk_counts(input string tag, input int kv, input int st, input int er);
    chk({tag, ".key_valid_pulses"}, kv_cnt, kv);
    chk({tag, ".rx_strobe_pulses"}, st_cnt, st);
    chk({tag, ".frame_err_pulses"}, err_cnt, er);
  endtask

  initial begin
    vecs[0]  = '{8'h1D, 1'b0, 8'h1D, 8'h1D, 1, 1, 0};
    vecs[1]  = '{8'h1D, 1'b0, 8'h1D, 8'h1D, 0, 1, 0};
    vecs[2]  = '{8'h1D, 1'b0, 8'h1D, 8'h1D, 0, 1, 0};
    vecs[3]  = '{8'h1D, 1'b0, 8'h1D, 8'h1D, 0, 1, 0};
    vecs[4]  = '{8'hF0, 1'b0, 8'h1D, 8'hF0, 0, 1, 0};
    vecs[5]  = '{8'h1D, 1'b0, 8'h00, 8'h1D, 1, 1, 0};
    vecs[6]  = '{8'hE0, 1'b0, 8'h00, 8'hE0, 0, 1, 0};
    vecs[7]  = '{8'h75, 1'b0, 8'h75, 8'h75, 1, 1, 0};
    vecs[8]  = '{8'hE0, 1'b0, 8'h75, 8'hE0, 0, 1, 0};
    vecs[9]  = '{8'hF0, 1'b0, 8'h75, 8'hF0, 0, 1, 0};
    vecs[10] = '{8'h75, 1'b0, 8'h00, 8'h75, 1, 1, 0};
    vecs[11] = '{8'hF0, 1'b0, 8'h00, 8'hF0, 0, 1, 0};
    // Break for a key that is not held is ignored
    vecs[12] = '{8'h33, 1'b0, 8'h00, 8'h33, 0, 1, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[13] = '{8'h1C, 1'b1, 8'h00, 8'h33, 0, 0, 1};
`else
    vecs[13] = '{8'h1C, 1'b1, 8'h1C, 8'h1C, 1, 1, 0};
`endif

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset.key_code",  key_code,  8'h00);
    chk("reset.key_valid", key_valid, 1'b0);
    chk("reset.rx_byte",   rx_byte,   8'h00);
    chk("reset.rx_strobe", rx_strobe, 1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 14; v++) begin
      clear_counts();
      send_frame(vecs[v].dat, vecs[v].bad_par, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d.key_code", v), key_code, vecs[v].exp_key);
      chk($sformatf("vec%0d.rx_byte", v),  rx_byte,  vecs[v].exp_rx);
      chk_counts($sformatf("vec%0d", v), vecs[v].exp_kv, vecs[v].exp_st, vecs[v].exp_err);
    end

    // New make while another key is held: last pressed wins
    clear_counts();
    send_frame(8'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("replace.key_code", key_code, 8'h22);
    chk_counts("replace", 1, 1, 0);

    // High start bit: single clock pulse with data high
    clear_counts();
    send_bits(11'h7FF, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("start_err.key_code", key_code, 8'h22);
    chk_counts("start_err", 0, 0, 1);

    // Low stop bit discards the byte
    clear_counts();
    send_frame(8'h1D, 1'b0, 1'b1);
    @(negedge clk);
    chk("stop_err.key_code", key_code, 8'h22);
    chk("stop_err.rx_byte",  rx_byte,  8'h22);
    chk_counts("stop_err", 0, 0, 1);

    // Five bits, then the PS/2 clock stalls past the timeout
    clear_counts();
    send_bits(11'h000, 5);
    ps2_data = 1'b1;
    repeat (TO_CYC + 100) @(posedge clk);
    @(negedge clk);
    chk_counts("timeout", 0, 0, 1);
    clear_counts();
    send_frame(8'h29, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_timeout.key_code", key_code, 8'h29);
    chk("post_timeout.rx_byte",  rx_byte,  8'h29);
    chk_counts("post_timeout", 1, 1, 0);

    // Reset after start plus four data bits
    send_bits(11'h000, 5);
    rst = 1'b1;
    #1;
    chk("rst_mid.key_code",  key_code,  8'h00);
    chk("rst_mid.rx_byte",   rx_byte,   8'h00);
    chk("rst_mid.key_valid", key_valid, 1'b0);
    chk("rst_mid.rx_strobe", rx_strobe, 1'b0);
    chk("rst_mid.frame_err", frame_err, 1'b0);
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    clear_counts();
    send_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst.key_code", key_code, 8'h5A);
    chk("post_rst.rx_byte",  rx_byte,  8'h5A);
    chk_counts("post_rst", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d, errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
